// File: rtl/mips_multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer:
// state enum, opcode/funct constants, ALUOp codes and datapath mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_LUI_WB   = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALUOp codes understood by the downstream ALU control
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // Register-file write-data select
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;
    localparam logic [1:0] M2R_LUI    = 2'd3;

    // ALU operand B select
    localparam logic [1:0] ALUB_B      = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    // R-type functions the datapath implements (jr is dispatched separately)
    function automatic logic funct_defined(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bundle between the control sequencer (master) and the datapath (slave):
// instruction fields and status in, strobes and mux selects out.
interface mips_mc_if;
    logic       run;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_instr;
    logic       mem_timeout;
    logic       instr_retired;
    logic [3:0] state_dbg;

    modport master (
        input  run, opcode, funct, zero, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_instr, mem_timeout, instr_retired, state_dbg
    );

    modport slave (
        output run, opcode, funct, zero, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_instr, mem_timeout, instr_retired, state_dbg
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath strobes.
// Memory states stall on mem_ready with an optional timeout.
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic      clk,
    input  logic      reset,
    mips_mc_if.master bus
);

    // Value of the wait counter on the last permitted stalled cycle.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic       in_mem_wait;
    logic       wait_expire;

    // Identify memory-wait states and the cycle on which the wait expires.
    always_comb begin
        in_mem_wait = ((state_q == S_FETCH) && bus.run) ||
                      (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        wait_expire = in_mem_wait && (MEM_WAIT_MAX != 0) &&
                      !bus.mem_ready && (wait_q == WAIT_LAST);
    end

    // State register, wait counter and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state, counter and flag update.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;

        case (state_q)
            S_FETCH: begin
                if (bus.run && bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:               state_d = (bus.funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:           state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:         state_d = S_BRANCH;
                    OP_J, OP_JAL:           state_d = S_JUMP;
                    OP_LUI:                 state_d = S_LUI_WB;
                    default:                state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   state_d = funct_defined(bus.funct) ? S_R_WB : S_ILLEGAL;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) state_d = S_FETCH;
            end
            default:    state_d = S_FETCH;
        endcase

        // A stalled memory access either keeps counting or gives up and
        // returns to FETCH; a completing access leaves the counter cleared.
        if (in_mem_wait && !bus.mem_ready) begin
            if (wait_expire) begin
                state_d   = S_FETCH;
                timeout_d = 1'b1;
            end else if (MEM_WAIT_MAX != 0) begin
                wait_d = wait_q + 4'd1;
            end
        end

        if (state_d == S_ILLEGAL) illegal_d = 1'b1;
    end

    // Output decode from the current state, blanked while reset is high.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = REGDST_RT;
        bus.mem_to_reg    = M2R_ALUOUT;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = ALUB_B;
        bus.alu_op        = ALUOP_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.instr_retired = 1'b0;
        bus.illegal_instr = 1'b0;
        bus.mem_timeout   = 1'b0;
        bus.state_dbg     = 4'd0;

        if (!reset) begin
            bus.illegal_instr = illegal_q;
            bus.mem_timeout   = timeout_q;
            bus.state_dbg     = state_q;

            case (state_q)
                S_FETCH: begin
                    if (bus.run) begin
                        bus.mem_read  = 1'b1;
                        bus.alu_src_b = ALUB_FOUR;
                        bus.ir_write  = bus.mem_ready;
                        bus.pc_write  = bus.mem_ready;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b = ALUB_IMM_SH;
                end
                S_EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALUOP_RTYPE;
                end
                S_EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALUB_IMM;
                    case (bus.opcode)
                        OP_ANDI: bus.alu_op = ALUOP_AND;
                        OP_ORI:  bus.alu_op = ALUOP_OR;
                        default: bus.alu_op = ALUOP_ADD;
                    endcase
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALUB_IMM;
                end
                S_MEM_RD: begin
                    bus.iord     = 1'b1;
                    bus.mem_read = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.mem_to_reg    = M2R_MDR;
                    bus.instr_retired = 1'b1;
                end
                S_MEM_WR: begin
                    bus.iord          = 1'b1;
                    bus.mem_write     = 1'b1;
                    bus.instr_retired = bus.mem_ready;
                end
                S_R_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.reg_dst       = REGDST_RD;
                    bus.instr_retired = 1'b1;
                end
                S_I_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALUOP_SUB;
                    bus.pc_source     = PCSRC_ALUOUT;
                    bus.pc_write      = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                                        ((bus.opcode == OP_BNE) && !bus.zero);
                    bus.instr_retired = 1'b1;
                end
                S_JUMP: begin
                    bus.pc_source     = PCSRC_JUMP;
                    bus.pc_write      = 1'b1;
                    bus.instr_retired = 1'b1;
                    if (bus.opcode == OP_JAL) begin
                        bus.reg_write  = 1'b1;
                        bus.reg_dst    = REGDST_RA;
                        bus.mem_to_reg = M2R_PC;
                    end
                end
                S_JR: begin
                    bus.pc_source     = PCSRC_REG;
                    bus.pc_write      = 1'b1;
                    bus.instr_retired = 1'b1;
                end
                S_LUI_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.mem_to_reg    = M2R_LUI;
                    bus.instr_retired = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle MIPS control sequencer: a table of
// per-cycle input/expected-output records plus memory-timeout sequences.
module tb_mips_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mips_mc_if bus ();

    mips_multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, iord, mrd, mwr, irw, rw;
        logic [1:0] rdst, m2r;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] psrc;
        logic       ill, tmo, ret;
    } out_t;

    typedef struct {
        string      name;
        logic       rst, run;
        logic [5:0] op, fn;
        logic       z, rdy;
        out_t       exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic out_t E(input logic [3:0] st, input logic pcw, iord, mrd, mwr, irw, rw,
                               input logic [1:0] rdst, m2r, input logic asa,
                               input logic [1:0] asb, input logic [2:0] aop,
                               input logic [1:0] psrc, input logic ill, tmo, ret);
        out_t o;
        o.st = st; o.pcw = pcw; o.iord = iord; o.mrd = mrd; o.mwr = mwr; o.irw = irw;
        o.rw = rw; o.rdst = rdst; o.m2r = m2r; o.asa = asa; o.asb = asb; o.aop = aop;
        o.psrc = psrc; o.ill = ill; o.tmo = tmo; o.ret = ret;
        return o;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.st = bus.state_dbg; a.pcw = bus.pc_write; a.iord = bus.iord;
        a.mrd = bus.mem_read; a.mwr = bus.mem_write; a.irw = bus.ir_write;
        a.rw = bus.reg_write; a.rdst = bus.reg_dst; a.m2r = bus.mem_to_reg;
        a.asa = bus.alu_src_a; a.asb = bus.alu_src_b; a.aop = bus.alu_op;
        a.psrc = bus.pc_source; a.ill = bus.illegal_instr; a.tmo = bus.mem_timeout;
        a.ret = bus.instr_retired;
        return a;
    endfunction

    task automatic add(input string nm, input logic rst, run, input logic [5:0] op, fn,
                       input logic z, rdy, input out_t e);
        vec_t v;
        v.name = nm; v.rst = rst; v.run = run; v.op = op; v.fn = fn;
        v.z = z; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk_vec(input string nm, input out_t act, input out_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic drive(input logic rst, run, input logic [5:0] op, fn, input logic z, rdy);
        reset = rst; bus.run = run; bus.opcode = op; bus.funct = fn;
        bus.zero = z; bus.mem_ready = rdy;
    endtask

    out_t Z0, F0, F1, D0, D1;

    initial begin
        drive(1'b1, 1'b1, 6'h00, 6'h20, 1'b0, 1'b1);

        Z0 = E(0, 0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0);
        F0 = E(0, 1,0,1,0,1,0, 0,0, 0,1,0,0, 0,0,0);
        F1 = E(0, 1,0,1,0,1,0, 0,0, 0,1,0,0, 1,0,0);
        D0 = E(1, 0,0,0,0,0,0, 0,0, 0,3,0,0, 0,0,0);
        D1 = E(1, 0,0,0,0,0,0, 0,0, 0,3,0,0, 1,0,0);

        // reset then add
        add("reset_c1",   1,1,6'h00,6'h20,0,1, Z0);
        add("reset_c2",   1,1,6'h00,6'h20,0,1, Z0);
        add("add_fetch",  0,1,6'h00,6'h20,0,1, F0);
        add("add_decode", 0,1,6'h00,6'h20,0,1, D0);
        add("add_exec",   0,1,6'h00,6'h20,0,1, E(2, 0,0,0,0,0,0, 0,0, 1,0,7,0, 0,0,0));
        add("add_wb",     0,1,6'h00,6'h20,0,1, E(8, 0,0,0,0,0,1, 1,0, 0,0,0,0, 0,0,1));
        // lw with three stalled read cycles
        add("lw_fetch",   0,1,6'h23,6'h00,0,1, F0);
        add("lw_decode",  0,1,6'h23,6'h00,0,1, D0);
        add("lw_addr",    0,1,6'h23,6'h00,0,1, E(4, 0,0,0,0,0,0, 0,0, 1,2,0,0, 0,0,0));
        add("lw_rd_w1",   0,1,6'h23,6'h00,0,0, E(5, 0,1,1,0,0,0, 0,0, 0,0,0,0, 0,0,0));
        add("lw_rd_w2",   0,1,6'h23,6'h00,0,0, E(5, 0,1,1,0,0,0, 0,0, 0,0,0,0, 0,0,0));
        add("lw_rd_w3",   0,1,6'h23,6'h00,0,0, E(5, 0,1,1,0,0,0, 0,0, 0,0,0,0, 0,0,0));
        add("lw_rd_done", 0,1,6'h23,6'h00,0,1, E(5, 0,1,1,0,0,0, 0,0, 0,0,0,0, 0,0,0));
        add("lw_wb",      0,1,6'h23,6'h00,0,1, E(6, 0,0,0,0,0,1, 0,1, 0,0,0,0, 0,0,1));
        // branches
        add("beq1_fetch", 0,1,6'h04,6'h00,1,1, F0);
        add("beq1_dec",   0,1,6'h04,6'h00,1,1, D0);
        add("beq_taken",  0,1,6'h04,6'h00,1,1, E(10, 1,0,0,0,0,0, 0,0, 1,0,1,1, 0,0,1));
        add("beq0_fetch", 0,1,6'h04,6'h00,0,1, F0);
        add("beq0_dec",   0,1,6'h04,6'h00,0,1, D0);
        add("beq_nottkn", 0,1,6'h04,6'h00,0,1, E(10, 0,0,0,0,0,0, 0,0, 1,0,1,1, 0,0,1));
        add("bne0_fetch", 0,1,6'h05,6'h00,0,1, F0);
        add("bne0_dec",   0,1,6'h05,6'h00,0,1, D0);
        add("bne_taken",  0,1,6'h05,6'h00,0,1, E(10, 1,0,0,0,0,0, 0,0, 1,0,1,1, 0,0,1));
        add("bne1_fetch", 0,1,6'h05,6'h00,1,1, F0);
        add("bne1_dec",   0,1,6'h05,6'h00,1,1, D0);
        add("bne_nottkn", 0,1,6'h05,6'h00,1,1, E(10, 0,0,0,0,0,0, 0,0, 1,0,1,1, 0,0,1));
        // jumps
        add("jal_fetch",  0,1,6'h03,6'h00,0,1, F0);
        add("jal_dec",    0,1,6'h03,6'h00,0,1, D0);
        add("jal_jump",   0,1,6'h03,6'h00,0,1, E(11, 1,0,0,0,0,1, 2,2, 0,0,0,2, 0,0,1));
        add("j_fetch",    0,1,6'h02,6'h00,0,1, F0);
        add("j_dec",      0,1,6'h02,6'h00,0,1, D0);
        add("j_jump",     0,1,6'h02,6'h00,0,1, E(11, 1,0,0,0,0,0, 0,0, 0,0,0,2, 0,0,1));
        // immediates and lui
        add("ori_fetch",  0,1,6'h0D,6'h00,0,1, F0);
        add("ori_dec",    0,1,6'h0D,6'h00,0,1, D0);
        add("ori_exec",   0,1,6'h0D,6'h00,0,1, E(3, 0,0,0,0,0,0, 0,0, 1,2,3,0, 0,0,0));
        add("ori_wb",     0,1,6'h0D,6'h00,0,1, E(9, 0,0,0,0,0,1, 0,0, 0,0,0,0, 0,0,1));
        add("lui_fetch",  0,1,6'h0F,6'h00,0,1, F0);
        add("lui_dec",    0,1,6'h0F,6'h00,0,1, D0);
        add("lui_wb",     0,1,6'h0F,6'h00,0,1, E(13, 0,0,0,0,0,1, 0,3, 0,0,0,0, 0,0,1));
        // jr
        add("jr_fetch",   0,1,6'h00,6'h08,0,1, F0);
        add("jr_dec",     0,1,6'h00,6'h08,0,1, D0);
        add("jr_exec",    0,1,6'h00,6'h08,0,1, E(12, 1,0,0,0,0,0, 0,0, 0,0,0,3, 0,0,1));
        // undefined funct, then undefined opcode; flag is sticky
        add("badfn_fetch",0,1,6'h00,6'h3F,0,1, F0);
        add("badfn_dec",  0,1,6'h00,6'h3F,0,1, D0);
        add("badfn_exec", 0,1,6'h00,6'h3F,0,1, E(2, 0,0,0,0,0,0, 0,0, 1,0,7,0, 0,0,0));
        add("badfn_ill",  0,1,6'h00,6'h3F,0,1, E(14, 0,0,0,0,0,0, 0,0, 0,0,0,0, 1,0,0));
        add("badop_fetch",0,1,6'h3F,6'h00,0,1, F1);
        add("badop_dec",  0,1,6'h3F,6'h00,0,1, D1);
        add("badop_ill",  0,1,6'h3F,6'h00,0,1, E(14, 0,0,0,0,0,0, 0,0, 0,0,0,0, 1,0,0));
        // sw interrupted by reset while stalled in MEM_WR
        add("swr_fetch",  0,1,6'h2B,6'h00,0,1, F1);
        add("swr_dec",    0,1,6'h2B,6'h00,0,1, D1);
        add("swr_addr",   0,1,6'h2B,6'h00,0,1, E(4, 0,0,0,0,0,0, 0,0, 1,2,0,0, 1,0,0));
        add("swr_wr_wait",0,1,6'h2B,6'h00,0,0, E(7, 0,1,0,1,0,0, 0,0, 0,0,0,0, 1,0,0));
        add("swr_reset",  1,1,6'h2B,6'h00,0,0, Z0);
        add("idle_run0a", 0,0,6'h2B,6'h00,0,1, Z0);
        add("idle_run0b", 0,0,6'h2B,6'h00,0,1, Z0);
        // sw completing normally
        add("sw_fetch",   0,1,6'h2B,6'h00,0,1, F0);
        add("sw_dec",     0,1,6'h2B,6'h00,0,1, D0);
        add("sw_addr",    0,1,6'h2B,6'h00,0,1, E(4, 0,0,0,0,0,0, 0,0, 1,2,0,0, 0,0,0));
        add("sw_wr",      0,1,6'h2B,6'h00,0,1, E(7, 0,1,0,1,0,0, 0,0, 0,0,0,0, 0,0,1));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].run, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy);
            #1;
            chk_vec(tbl[i].name, sample(), tbl[i].exp);
        end

        // FETCH stuck waiting: timeout after 15 stalled cycles, then retry
        @(negedge clk);
        drive(1'b1, 1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            #1;
            chk($sformatf("to_wait%0d_tmo", i), {3'b0, bus.mem_timeout}, 4'd0);
            chk($sformatf("to_wait%0d_rd", i), {2'b0, bus.mem_read, bus.ir_write}, 4'b0010);
            @(negedge clk);
        end
        #1;
        chk("to_flag", {3'b0, bus.mem_timeout}, 4'd1);
        chk("to_state", bus.state_dbg, 4'd0);
        chk("to_retry_rd", {3'b0, bus.mem_read}, 4'd1);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk("to_retry_ir", {2'b0, bus.ir_write, bus.pc_write}, 4'b0011);
        chk("to_sticky", {3'b0, bus.mem_timeout}, 4'd1);
        @(negedge clk);
        #1;
        chk("to_retry_dec", bus.state_dbg, 4'd1);

        // Completion on the limit cycle beats the timeout
        @(negedge clk);
        drive(1'b1, 1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
        #1;
        chk("lim_reset_clr", {3'b0, bus.mem_timeout}, 4'd0);
        for (int i = 0; i < 14; i++) @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk("lim_ir_write", {3'b0, bus.ir_write}, 4'd1);
        chk("lim_no_tmo", {3'b0, bus.mem_timeout}, 4'd0);
        @(negedge clk);
        #1;
        chk("lim_decode", bus.state_dbg, 4'd1);
        chk("lim_no_tmo2", {3'b0, bus.mem_timeout}, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath: replaces the single-cycle combinational decoder.
- Walks each instruction through fetch/decode/execute/memory/writeback states and drives every datapath strobe and mux select.
- Sits between the instruction register (opcode/funct) and the shared PC, register file, ALU and unified memory.
- Stalls on a memory ready handshake.

Parameters:
- MEM_WAIT_MAX, 15: cycles a memory state waits for mem_ready before flagging timeout; 0 disables timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; forces FETCH and clears flags
- run  input  1  when low, sequencer idles in FETCH without issuing a fetch
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, same-cycle combinational
- mem_ready  input  1  memory completes current read/write this cycle
- pc_write  output  1  load PC (already gated for branches)
- iord  output  1  0 = PC addresses memory, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  latch instruction register
- reg_write  output  1  register file write enable
- reg_dst  output  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg  output  2  0 = ALUOut, 1 = MDR, 2 = PC, 3 = LUI value
- alu_src_a  output  1  0 = PC, 1 = A register
- alu_src_b  output  2  0 = B, 1 = constant 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- alu_op  output  3  ALUOp code to the existing ALU control
- pc_source  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A (jr)
- illegal_instr  output  1  sticky; set on undefined opcode or funct
- mem_timeout  output  1  sticky; set when a memory state waits MEM_WAIT_MAX cycles
- instr_retired  output  1  one-cycle pulse on the final cycle of each instruction
- state_dbg  output  4  current state encoding

Behaviour:
- State register and the wait counter (4 bits) update on posedge clk.
- Outputs are decoded from state, gated with mem_ready/zero where noted, and are 0 in all states unless listed.
- Reset:
  - reset high at an edge -> state = FETCH, wait counter = 0, illegal_instr = 0, mem_timeout = 0.
  - While reset is high, all outputs are forced to 0, including state_dbg.
  - Reset mid-instruction abandons that instruction; there is no partial writeback after the reset edge.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JR, LUI_WB, ILLEGAL.
- FETCH:
  - If run = 0: no strobes; stay in FETCH.
  - Else: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = ADD, pc_source = 0.
  - ir_write and pc_write assert only in the cycle mem_ready = 1; then go to DECODE. Otherwise stay.
- DECODE: alu_src_a = 0, alu_src_b = 3, alu_op = ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x00 with funct 0x08 -> JR.
  - 0x00 otherwise -> EXEC_R.
  - 0x08, 0x0C, 0x0D -> EXEC_I.
  - 0x23, 0x2B -> MEM_ADDR.
  - 0x04, 0x05 -> BRANCH.
  - 0x02, 0x03 -> JUMP.
  - 0x0F -> LUI_WB.
  - Any other opcode -> ILLEGAL.
- EXEC_R:
  - alu_src_a = 1, alu_src_b = 0, alu_op = RTYPE -> R_WB.
  - Undefined funct -> ILLEGAL. Defined funct: 0x20, 0x22, 0x24, 0x25, 0x27, 0x00, 0x02.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_retired -> FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, alu_op = ADD / AND / OR for addi / andi / ori -> I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_retired -> FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = ADD -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: iord = 1, mem_read = 1; on mem_ready -> MEM_WB.
- MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1, instr_retired -> FETCH.
- MEM_WR: iord = 1, mem_write = 1; on mem_ready -> instr_retired, FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 0, alu_op = SUB, pc_source = 1.
  - pc_write = (opcode==0x04 & zero) | (opcode==0x05 & ~zero).
  - instr_retired -> FETCH.
- JUMP:
  - pc_source = 2, pc_write = 1.
  - If opcode 0x03 (jal): reg_write = 1, reg_dst = 2, mem_to_reg = 2; PC still holds PC+4 this cycle.
  - instr_retired -> FETCH.
- JR: pc_source = 3, pc_write = 1, instr_retired -> FETCH.
- LUI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 3, instr_retired -> FETCH.
- ILLEGAL: set illegal_instr; no strobes; no retire -> FETCH. PC has already advanced past the bad word.
- Memory wait (FETCH with run = 1, MEM_RD, MEM_WR):
  - The wait counter increments each cycle mem_ready = 0 and clears on state exit.
  - When it reaches MEM_WAIT_MAX: set mem_timeout, drop the request, go to FETCH. A timed-out FETCH retries the same PC.
  - mem_ready = 1 in the same cycle the counter hits the limit: completion wins, no timeout.
- run deasserted mid-instruction has no effect until the next FETCH.
- Latency with mem_ready tied high:
  - R / I / lui: 4 cycles (lui: 3).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq / bne / j / jal / jr: 3 cycles.

Decomposition:
- Package mips_mc_pkg holds:
  - State enum.
  - Opcode and funct constants.
  - ALUOp codes: ADD = 000, SUB = 001, AND = 010, OR = 011, RTYPE = 111.
  - Select encodings for reg_dst, mem_to_reg, alu_src_b, pc_source.
- Single module; the output decode is a case on state. No sub-module.

Test Plan:
- reset high for 2 cycles, then low with run = 1, mem_ready = 1 -> state_dbg = FETCH; first cycle has mem_read = 1, ir_write = 1, pc_write = 1, alu_src_b = 1.
- add (opcode 0, funct 0x20) -> DECODE, EXEC_R (alu_op = 111), R_WB (reg_write = 1, reg_dst = 1); instr_retired on cycle 4.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD -> mem_read held with iord = 1 for 4 cycles; then MEM_WB with mem_to_reg = 1; total 8 cycles.
- beq (0x04): zero = 1 -> pc_write = 1, pc_source = 1. Repeat with zero = 0 -> pc_write = 0. bne (0x05) with zero = 0 -> pc_write = 1.
- jal (0x03) -> JUMP cycle shows pc_write = 1, pc_source = 2, reg_write = 1, reg_dst = 2, mem_to_reg = 2.
- opcode 0x3F -> ILLEGAL, illegal_instr = 1 and sticky, no retire, back to FETCH. MEM_WAIT_MAX = 15 with mem_ready stuck low in FETCH -> mem_timeout = 1 after 15 cycles. Reset asserted in MEM_WR -> mem_write = 0 immediately, FETCH next.
